alu_sched: RTL

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_pkg.sv | 24 ++
 rtl/alu.sv | 46 ++++
 rtl/alu_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared opcodes, FSM encoding and helpers for alu_sched
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SHR = 3'd1;
  localparam logic [2:0] OP_SHL = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Only the arithmetic and shift opcodes produce a meaningful carry-out.
  function automatic logic op_has_cout(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: add, shifts, logic ops and compare flags
module alu
  import alu_sched_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [2:0]      op,
  input  logic            cin,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] c,
  output logic            cout,
  output logic            zero,
  output logic            equal,
  output logic            a_larger
);

  logic [SIZE:0] sum;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
    c    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: {cout, c} = sum;
      OP_SHR: begin
        c    = {cin, a[SIZE-1:1]};
        cout = a[0];
      end
      OP_SHL: begin
        c    = {a[SIZE-2:0], cin};
        cout = a[SIZE-1];
      end
      OP_NOT: c = ~a;
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      default: c = '0;
    endcase
  end

  assign zero     = (c == '0);
  assign equal    = (a == b);
  assign a_larger = (a > b);

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin front end serialising commands through one ALU
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic             r0_cin,
  input  logic [SIZE-1:0]  r0_a,
  input  logic [SIZE-1:0]  r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic             r1_cin,
  input  logic [SIZE-1:0]  r1_a,
  input  logic [SIZE-1:0]  r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [SIZE-1:0]  rsp_c,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_equal,
  output logic             rsp_a_larger,
  output logic [CNT_W-1:0] ops_done
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [2:0]        op_q, op_d;
  logic              cin_q, cin_d;
  logic [SIZE-1:0]   a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [SIZE-1:0]   rsp_c_q, rsp_c_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_equal_q, rsp_equal_d;
  logic              rsp_a_larger_q, rsp_a_larger_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              grant0, grant1;
  logic [SIZE-1:0]   alu_c;
  logic              alu_cout, alu_equal, alu_a_larger, alu_zero_unused;

  alu #(.SIZE(SIZE)) u_alu (
    .op       (op_q),
    .cin      (cin_q),
    .a        (a_q),
    .b        (b_q),
    .c        (alu_c),
    .cout     (alu_cout),
    .zero     (alu_zero_unused),
    .equal    (alu_equal),
    .a_larger (alu_a_larger)
  );

  // last_q = 1 means r1 won the previous grant, so r0 wins the next tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE) begin
      if (r0_valid && r1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    op_d           = op_q;
    cin_d          = cin_q;
    a_d            = a_q;
    b_d            = b_q;
    id_d           = id_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_c_d        = rsp_c_q;
    rsp_cout_d     = rsp_cout_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_equal_d    = rsp_equal_q;
    rsp_a_larger_d = rsp_a_larger_q;
    ops_done_d     = ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          state_d = ST_EXEC;
          last_d  = grant1;
          id_d    = grant1;
          op_d    = grant1 ? r1_op  : r0_op;
          cin_d   = grant1 ? r1_cin : r0_cin;
          a_d     = grant1 ? r1_a   : r0_a;
          b_d     = grant1 ? r1_b   : r0_b;
        end
      end
      ST_EXEC: begin
        state_d        = ST_RESP;
        rsp_valid_d    = 1'b1;
        rsp_id_d       = id_q;
        rsp_c_d        = alu_c;
        rsp_cout_d     = op_has_cout(op_q) & alu_cout;
        rsp_zero_d     = (alu_c == '0);
        rsp_equal_d    = alu_equal;
        rsp_a_larger_d = alu_a_larger;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_q         <= 1'b1;
      op_q           <= '0;
      cin_q          <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_c_q        <= '0;
      rsp_cout_q     <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_equal_q    <= 1'b0;
      rsp_a_larger_q <= 1'b0;
      ops_done_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      op_q           <= op_d;
      cin_q          <= cin_d;
      a_q            <= a_d;
      b_q            <= b_d;
      id_q           <= id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_c_q        <= rsp_c_d;
      rsp_cout_q     <= rsp_cout_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_equal_q    <= rsp_equal_d;
      rsp_a_larger_q <= rsp_a_larger_d;
      ops_done_q     <= ops_done_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_c        = rsp_c_q;
  assign rsp_cout     = rsp_cout_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_equal    = rsp_equal_q;
  assign rsp_a_larger = rsp_a_larger_q;
  assign ops_done     = ops_done_q;

endmodule
